// File: rtl/memd_arb_pkg.sv
// memd_arb_pkg: shared types and default widths for the memd load arbiter.
// Default widths come from the shared MEMD_SIZE / REG_LEN / MEMD_ARB_NREQ /
// MEMD_ARB_TAG_W macros; fallback values keep this slice buildable stand-alone.
// Feature macro MEMD_ARB_RR_EN (round-robin priority) is consumed by memd_arb.
`ifndef MEMD_SIZE
`define MEMD_SIZE 8
`endif
`ifndef REG_LEN
`define REG_LEN 16
`endif
`ifndef MEMD_ARB_NREQ
`define MEMD_ARB_NREQ 4
`endif
`ifndef MEMD_ARB_TAG_W
`define MEMD_ARB_TAG_W 4
`endif

package memd_arb_pkg;

  localparam int MEMD_ARB_ADDR_W = `MEMD_SIZE;
  localparam int MEMD_ARB_DATA_W = `REG_LEN;
  localparam int MEMD_ARB_NREQ   = `MEMD_ARB_NREQ;
  localparam int MEMD_ARB_TAG_W  = `MEMD_ARB_TAG_W;

  // Arbiter occupancy: IDLE = memd free, BUSY = one access outstanding,
  // SQUASH = outstanding access whose data will be dropped on return.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_SQUASH = 2'd2
  } arb_state_e;

  typedef enum logic {
    PICK_FIXED = 1'b0,
    PICK_RR    = 1'b1
  } pick_mode_e;

endpackage

// File: rtl/memd_arb_rr_pick.sv
// rr_pick: selects one requester. Fixed mode: lowest index wins.
// Round-robin mode: search starts at ptr+1 and wraps modulo NREQ.
module rr_pick
  import memd_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  pick_mode_e       mode,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  // Scan candidates in priority order and take the first valid one.
  always_comb begin
    int   cand;
    logic found;
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (mode == PICK_RR) ? ((int'(ptr) + 1 + k) % NREQ) : k;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/memd_arb.sv
// memd_arb: shares the single-ported, variable-latency memd among NREQ load
// requesters. One access outstanding at a time; issue may overlap the return
// cycle. Flush squashes the outstanding access (its data is dropped).
// Define MEMD_ARB_RR_EN for round-robin priority; otherwise fixed priority.
module memd_arb
  import memd_arb_pkg::*;
#(
  parameter int NREQ   = MEMD_ARB_NREQ,
  parameter int ADDR_W = MEMD_ARB_ADDR_W,
  parameter int DATA_W = MEMD_ARB_DATA_W,
  parameter int TAG_W  = MEMD_ARB_TAG_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*ADDR_W-1:0]  req_addr,
  input  logic [NREQ*TAG_W-1:0]   req_tag,
  output logic [NREQ-1:0]         req_grant,
  input  logic                    flush,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic [TAG_W-1:0]        resp_tag,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic                    mem_out_valid
);

  localparam int IDX_W = $clog2(NREQ);

`ifdef MEMD_ARB_RR_EN
  localparam pick_mode_e PICK_MODE = PICK_RR;
`else
  localparam pick_mode_e PICK_MODE = PICK_FIXED;
`endif

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  cur_id_q;
  logic [TAG_W-1:0]  cur_tag_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  prio_ptr_q;

  logic [NREQ-1:0]   pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [TAG_W-1:0]  win_tag;
  logic              busy, squash, issue, ret, resp_fire;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (prio_ptr_q),
    .mode  (PICK_MODE),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign win_addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
  assign win_tag   = req_tag[pick_idx*TAG_W +: TAG_W];

  assign busy      = (state_q != ST_IDLE);
  assign squash    = (state_q == ST_SQUASH);
  // Issue may overlap the return cycle of the outstanding access.
  assign issue     = !rst && !flush && mem_ready && (|req_valid) && (!busy || mem_out_valid);
  assign ret       = busy && mem_out_valid;
  assign resp_fire = !rst && ret && !squash && !flush;

  // Next-state and combinational outputs; responses use cur_* before the
  // same-cycle issue overwrites them.
  always_comb begin
    state_d    = state_q;
    req_grant  = '0;
    mem_valid  = issue;
    mem_addr   = '0;
    resp_valid = resp_fire;
    resp_data  = '0;
    resp_id    = '0;
    resp_tag   = '0;

    if (issue) begin
      req_grant = pick_grant;
      mem_addr  = win_addr;
    end else if (!rst) begin
      // Hold the last issued address: memd counts down against it.
      mem_addr  = addr_q;
    end

    if (resp_fire) begin
      resp_data = mem_data;
      resp_id   = cur_id_q;
      resp_tag  = cur_tag_q;
    end

    if (issue) begin
      state_d = ST_BUSY;
    end else if (ret) begin
      state_d = ST_IDLE;
    end else if (busy && flush) begin
      state_d = ST_SQUASH;
    end
  end

  // State register and issued-access bookkeeping, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_id_q   <= '0;
      cur_tag_q  <= '0;
      addr_q     <= '0;
      prio_ptr_q <= IDX_W'(NREQ - 1);
    end else begin
      state_q <= state_d;
      if (issue) begin
        cur_id_q   <= pick_idx;
        cur_tag_q  <= win_tag;
        addr_q     <= win_addr;
        prio_ptr_q <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_memd_arb.sv
// tb_memd_arb: directed self-checking bench for memd_arb with a behavioural
// memd (latency addr+1 cycles) and a response scoreboard.
module tb_memd_arb;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*ADDR_W-1:0]  req_addr;
  logic [NREQ*TAG_W-1:0]   req_tag;
  logic [NREQ-1:0]         req_grant;
  logic                    flush;
  logic                    resp_valid;
  logic [DATA_W-1:0]       resp_data;
  logic [1:0]              resp_id;
  logic [TAG_W-1:0]        resp_tag;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [DATA_W-1:0]       mem_data;
  logic                    mem_out_valid;

  logic [ADDR_W-1:0] a [NREQ];
  logic [TAG_W-1:0]  t [NREQ];

  typedef struct {
    logic [1:0]        id;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign req_addr = {a[3], a[2], a[1], a[0]};
  assign req_tag  = {t[3], t[2], t[1], t[0]};

  memd_arb #(
    .NREQ   (NREQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_tag       (req_tag),
    .req_grant     (req_grant),
    .flush         (flush),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_id       (resp_id),
    .resp_tag      (resp_tag),
    .mem_addr      (mem_addr),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_data      (mem_data),
    .mem_out_valid (mem_out_valid)
  );

  // Memory contents model.
  function automatic logic [DATA_W-1:0] memd_word(input logic [ADDR_W-1:0] addr);
    return 16'hD000 ^ {addr, ~addr};
  endfunction

  // Behavioural memd: data for address a returns a+1 cycles after acceptance.
  logic              m_pend;
  logic [ADDR_W-1:0] m_cnt;
  logic [ADDR_W-1:0] m_addr;

  assign mem_out_valid = m_pend && (m_cnt == '0);
  assign mem_ready     = !m_pend || mem_out_valid;
  assign mem_data      = mem_out_valid ? memd_word(m_addr) : 16'h5A5A;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_cnt  <= '0;
      m_addr <= '0;
    end else if (mem_valid) begin
      m_pend <= 1'b1;
      m_cnt  <= mem_addr;
      m_addr <= mem_addr;
    end else if (mem_out_valid) begin
      m_pend <= 1'b0;
    end else if (m_pend) begin
      m_cnt <= m_cnt - 1'b1;
    end
  end

  // One cycle: compare outputs at the falling edge, then advance past the
  // rising edge. exp_g is the required grant, exp_rv the required resp_valid.
  task automatic tick(input logic [NREQ-1:0] exp_g, input logic exp_rv, input string tag);
    int   idx;
    exp_t e;
    @(negedge clk);
    tests++;
    assert (req_grant === exp_g) else begin
      fails++; $error("FAIL %s grant got %b exp %b", tag, req_grant, exp_g);
    end
    tests++;
    assert (mem_valid === (exp_g != '0)) else begin
      fails++; $error("FAIL %s mem_valid got %b exp %b", tag, mem_valid, (exp_g != '0));
    end
    if (exp_g != '0) begin
      idx = 0;
      for (int i = 0; i < NREQ; i++) if (exp_g[i]) idx = i;
      tests++;
      assert (mem_addr === a[idx]) else begin
        fails++; $error("FAIL %s mem_addr got %0d exp %0d", tag, mem_addr, a[idx]);
      end
      e.id   = idx[1:0];
      e.tag  = t[idx];
      e.data = memd_word(a[idx]);
      sb.push_back(e);
    end
    if (rst) begin
      tests++;
      assert (mem_addr === '0) else begin
        fails++; $error("FAIL %s mem_addr in reset got %0d exp 0", tag, mem_addr);
      end
    end
    tests++;
    assert (resp_valid === exp_rv) else begin
      fails++; $error("FAIL %s resp_valid got %b exp %b", tag, resp_valid, exp_rv);
    end
    if (resp_valid === 1'b1) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++; $error("FAIL %s unexpected response got id %0d exp none", tag, resp_id);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        tests++;
        assert (resp_id === e.id && resp_tag === e.tag && resp_data === e.data) else begin
          fails++;
          $error("FAIL %s resp got id %0d tag %0d data %h exp id %0d tag %0d data %h",
                 tag, resp_id, resp_tag, resp_data, e.id, e.tag, e.data);
        end
      end
    end else begin
      tests++;
      assert ({resp_data, resp_id, resp_tag} === '0) else begin
        fails++; $error("FAIL %s idle resp fields got %h/%0d/%0d exp 0", tag, resp_data, resp_id, resp_tag);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drained(input string tag);
    tests++;
    assert (sb.size() == 0) else begin
      fails++; $error("FAIL %s pending responses got %0d exp 0", tag, sb.size());
    end
  endtask

  initial begin
    logic [NREQ-1:0] g;
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      t[i] = '0;
    end

    // Reset state.
    tick('0, 1'b0, "rst0");
    tick('0, 1'b0, "rst1");
    rst = 1'b0;

    // Single request: req 2, addr 0, tag 5 -> response one cycle later.
    a[2] = 8'd0; t[2] = 4'd5;
    req_valid = 4'b0100;
    tick(4'b0100, 1'b0, "single_grant");
    req_valid = '0;
    tick('0, 1'b1, "single_resp");
    drained("single_done");

    // Back-to-back: response of id 1 and grant of id 3 in the same cycle.
    a[1] = 8'd1; t[1] = 4'd3;
    req_valid = 4'b0010;
    tick(4'b0010, 1'b0, "b2b_grant1");
    a[3] = 8'd2; t[3] = 4'd9;
    req_valid = 4'b1000;
    tick('0, 1'b0, "b2b_busy");
    tick(4'b1000, 1'b1, "b2b_overlap");
    req_valid = '0;
    tick('0, 1'b0, "b2b_wait0");
    tick('0, 1'b0, "b2b_wait1");
    tick('0, 1'b1, "b2b_resp3");
    drained("b2b_done");

    // All four requesting continuously at addr 1, from a fresh reset.
    rst = 1'b1;
    tick('0, 1'b0, "rst_mid");
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 8'd1;
      t[i] = 4'(i + 8);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      g = '0;
      if (k % 2 == 0) begin
`ifdef MEMD_ARB_RR_EN
        g = 4'b0001 << ((k / 2) % NREQ);
`else
        g = 4'b0001;
`endif
      end
      tick(g, (k >= 2) && (k % 2 == 0), "all4");
    end
    req_valid = '0;
    tick('0, 1'b0, "all4_wait");
    tick('0, 1'b1, "all4_last");
    drained("all4_done");

    // Flush one cycle after issuing addr 3: no response, grant only at return.
    a[0] = 8'd3; t[0] = 4'd7;
    req_valid = 4'b0001;
    tick(4'b0001, 1'b0, "flush_issue");
    flush = 1'b1;
    void'(sb.pop_back());
    tick('0, 1'b0, "flush_cycle");
    flush = 1'b0;
    tick('0, 1'b0, "flush_hold0");
    tick('0, 1'b0, "flush_hold1");
    tick(4'b0001, 1'b0, "flush_ret_grant");

    // Flush in the same cycle as mem_out_valid: dropped, no grant.
    req_valid = '0;
    tick('0, 1'b0, "fret_wait0");
    tick('0, 1'b0, "fret_wait1");
    tick('0, 1'b0, "fret_wait2");
    req_valid = 4'b0001;
    flush = 1'b1;
    void'(sb.pop_back());
    tick('0, 1'b0, "fret_flush");
    flush = 1'b0;
    tick(4'b0001, 1'b0, "fret_regrant");

    // Reset while busy: outputs zero, first grant afterwards to requester 0.
    rst = 1'b1;
    sb.delete();
    req_valid = 4'b1111;
    tick('0, 1'b0, "rst_busy0");
    tick('0, 1'b0, "rst_busy1");
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) a[i] = 8'd0;
    tick(4'b0001, 1'b0, "post_rst_grant");
    req_valid = '0;
    tick('0, 1'b1, "post_rst_resp");
    drained("post_rst_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
